// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the multiplexed 7-segment
// display controller.
//   SEG_BLANK  - all segments and the decimal point off (active-low)
//   OFS_DP     - offset of the decimal-point mask register, counted from the
//                end of the nibble window (N_DIGITS/2)
//   OFS_BLANK  - offset of the blank mask register, counted the same way
//   hex7()     - nibble to active-low a..g pattern (a = bit 6)
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         OFS_DP    = 0;
  localparam int         OFS_BLANK = 1;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h01;
      4'h1:    pat = 7'h4F;
      4'h2:    pat = 7'h12;
      4'h3:    pat = 7'h06;
      4'h4:    pat = 7'h4C;
      4'h5:    pat = 7'h24;
      4'h6:    pat = 7'h20;
      4'h7:    pat = 7'h0F;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h0C;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h60;
      4'hC:    pat = 7'h31;
      4'hD:    pat = 7'h42;
      4'hE:    pat = 7'h30;
      default: pat = 7'h38;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to active-low segment decoder.
//   nibble  in   4  value to display
//   seg_n   out  7  active-low a..g (a = bit 6)
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex7(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment controller driven from
// the PicoBlaze output port.
//   clk_d        in   1         system clock
//   reset        in   1         asynchronous, active-high reset
//   port_id      in   8         PicoBlaze port address
//   out_port     in   8         PicoBlaze write data
//   write_strobe in   1         write qualifier, one cycle
//   seg          out  8         active-low, [7]=dp, [6:0]=a..g
//   an           out  N_DIGITS  active-low one-hot anode select
//   scan_tick    out  1         one-cycle pulse when the digit index advances
// Register window (k = port_id - BASE_ADDR):
//   k < N_DIGITS/2   : two nibbles, low nibble -> digit 2k, high -> 2k+1
//   k = N_DIGITS/2   : decimal-point mask (1 = dp lit)
//   k = N_DIGITS/2+1 : blank mask (1 = digit dark, anode still scanned)
// Build option: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int         N_DIGITS  = 8,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         SCAN_DIV  = 100000,
  parameter int         BLANK_CYC = 16,
  parameter int         DIV_W     = $clog2(SCAN_DIV)
) (
  input  logic                clk_d,
  input  logic                reset,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                scan_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0] K_DP    = 8'(N_DIGITS / 2 + OFS_DP);
  localparam logic [7:0] K_BLANK = 8'(N_DIGITS / 2 + OFS_BLANK);
  localparam int unsigned BLANK_U = BLANK_CYC;

  logic [3:0]          nib [N_DIGITS];
  logic [N_DIGITS-1:0] dp_mask;
  logic [N_DIGITS-1:0] blank_mask;
  logic [DIV_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;

  logic [7:0]          k;
  logic                wrap;
  logic [DIV_W-1:0]    pre_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                gap;
  logic                lz_hide;
  logic [6:0]          hex_seg;
  logic [7:0]          seg_d;
  logic [N_DIGITS-1:0] an_d;

  // Register file
  assign k = port_id - BASE_ADDR;

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) nib[i] <= 4'h0;
      dp_mask    <= '0;
      blank_mask <= '0;
    end else if (write_strobe) begin
      for (int j = 0; j < N_DIGITS / 2; j++) begin
        if (k == 8'(j)) begin
          nib[2*j]   <= out_port[3:0];
          nib[2*j+1] <= out_port[7:4];
        end
      end
      if (k == K_DP)    dp_mask    <= out_port[N_DIGITS-1:0];
      if (k == K_BLANK) blank_mask <= out_port[N_DIGITS-1:0];
    end
  end

  // Scan timing. Outputs are computed from the next prescaler/index value
  // so that seg and an for a slot land on the same edge as the index change.
  always_comb begin
    wrap    = (pre == PRE_LAST);
    pre_nxt = wrap ? '0 : pre + 1'b1;
    idx_nxt = idx;
    if (wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    gap     = 32'(pre_nxt) < BLANK_U;
  end

`ifdef SEG7_LZB_EN
  // Highest digit holding a visible nonzero value; digit 0 is always shown
  // because hi never drops below 0.
  logic [IDX_W-1:0] hi;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (nib[i] != 4'h0 && !blank_mask[i]) hi = IDX_W'(i);
    end
  end
  assign lz_hide = (idx_nxt > hi);
`else
  assign lz_hide = 1'b0;
`endif

  seg7_hex_decoder u_dec (
    .nibble (nib[idx_nxt]),
    .seg_n  (hex_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (!gap) begin
      an_d = ~(N_DIGITS'(1) << idx_nxt);
      if (blank_mask[idx_nxt])
        seg_d = SEG_BLANK;
      else if (lz_hide)
        seg_d = {~dp_mask[idx_nxt], 7'h7F};
      else
        seg_d = {~dp_mask[idx_nxt], hex_seg};
    end
  end

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
      an        <= '1;
      seg       <= SEG_BLANK;
    end else begin
      pre       <= pre_nxt;
      idx       <= idx_nxt;
      scan_tick <= wrap;
      an        <= an_d;
      seg       <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int W = 17;

  logic       clk_d = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic [7:0] seg;
  logic [7:0] an;
  logic       scan_tick;

  seg7_scan_ctrl #(
    .N_DIGITS  (8),
    .BASE_ADDR (8'h10),
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .seg          (seg),
    .an           (an),
    .scan_tick    (scan_tick)
  );

  // clock
  always #5 clk_d = ~clk_d;

  // reference state
  logic [6:0]   hex_tb [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [3:0]   m_nib [8];
  logic [7:0]   m_dp;
  logic [7:0]   m_blank;
  logic [W-1:0] exp_q [$];
  int           n;
  int           tests = 0;
  int           fails = 0;
  logic         wr_pend = 1'b0;
  logic [7:0]   wr_addr, wr_data;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_dp    = 8'h00;
    m_blank = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] kk;
    kk = a - 8'h10;
    if (kk < 8'd4) begin
      m_nib[2*kk]   = d[3:0];
      m_nib[2*kk+1] = d[7:4];
    end else if (kk == 8'd4) m_dp = d;
    else if (kk == 8'd5) m_blank = d;
  endtask

  // Expected {scan_tick, an, seg} after the n-th rising edge since reset release.
  function automatic logic [W-1:0] expected(input int cyc);
    int         pre, id;
    logic [7:0] e_an, e_seg;
    logic       tick;
    int         hi;
    pre  = cyc % 4;
    id   = (cyc / 4) % 8;
    tick = (pre == 0);
    e_an  = 8'hFF;
    e_seg = 8'hFF;
    hi = 0;
    for (int i = 0; i < 8; i++) if (m_nib[i] != 0 && !m_blank[i]) hi = i;
    if (pre >= 1) begin
      e_an = ~(8'h01 << id);
      if (m_blank[id]) e_seg = 8'hFF;
`ifdef SEG7_LZB_EN
      else if (id > hi) e_seg = {~m_dp[id], 7'h7F};
`endif
      else e_seg = {~m_dp[id], hex_tb[m_nib[id]]};
    end
    return {tick, e_an, e_seg};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: push the expectation for this edge, fold in any write that
  // the edge commits, then compare once outputs have settled.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk_d);
    n++;
    exp_q.push_back(expected(n));
    if (wr_pend) begin
      model_write(wr_addr, wr_data);
      wr_pend = 1'b0;
    end
    #1;
    e = exp_q.pop_front();
    check($sformatf("cyc%0d", n), {scan_tick, an, seg}, e);
  endtask

  task automatic write_port(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    wr_addr      = a;
    wr_data      = d;
    wr_pend      = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    reset        = 1'b1;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    model_clear();
    n = 0;
    repeat (2) @(posedge clk_d);
    #1;
    check("reset_an",   {9'h0, an},        {9'h0, 8'hFF});
    check("reset_seg",  {9'h0, seg},       {9'h0, 8'hFF});
    check("reset_tick", {16'h0, scan_tick}, 17'h0);
    reset = 1'b0;

    // hex digits, full scans with tick spacing and blank gap
    write_port(8'h10, 8'h21);
    write_port(8'h11, 8'h43);
    write_port(8'h12, 8'h65);
    write_port(8'h13, 8'h87);
    run(64);

    // decimal points on digits 0 and 2, digit 7 blanked
    write_port(8'h14, 8'h05);
    write_port(8'h15, 8'h80);
    run(36);

    // writes outside the window change nothing
    write_port(8'h16, 8'hFF);
    write_port(8'h0F, 8'hFF);
    run(34);

    // async reset in the middle of slot 5
    for (int i = 0; i < 40; i++) begin
      if ((n % 4) == 2 && ((n / 4) % 8) == 5) break;
      step();
    end
    check("reached_slot5", {15'h0, 2'(((n / 4) % 8) == 5)}, 17'h1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_an",   {9'h0, an},         {9'h0, 8'hFF});
    check("midreset_seg",  {9'h0, seg},        {9'h0, 8'hFF});
    check("midreset_tick", {16'h0, scan_tick}, 17'h0);
    model_clear();
    @(negedge clk_d);
    reset = 1'b0;
    n = 0;
    run(36);

`ifdef SEG7_LZB_EN
    write_port(8'h10, 8'h00);
    write_port(8'h11, 8'h03);
    write_port(8'h12, 8'h00);
    write_port(8'h13, 8'h00);
    run(36);
    write_port(8'h11, 8'h00);
    run(36);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
